// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment encodings and Segment bit positions
package seg_pkg;

  // Bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} Segment bus
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high glyphs for hex digits, bit 0 = segment a
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to seven-segment glyph decoder
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup of the glyph for one nibble
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/segment_scanner.sv
// rtl/segment_scanner.sv - multiplexed seven-segment scanner with frame-synchronous load (option: SEG_LEADING_ZERO_BLANK_EN)
module segment_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic                    Load,
  output logic                    Ready,
  output logic [7:0]              Segment,
  output logic [NUM_DIGITS-1:0]   Digit_Sel,
  output logic                    Frame_Done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    frame_done_q, frame_done_d;

  logic       tick;
  logic       wrap;
  logic [3:0] sel_nibble;
  logic       sel_dp;
  logic [6:0] dec_seg;
  logic [6:0] seg_body;

  // Pick the nibble and decimal point of the digit currently being scanned
  always_comb begin
    sel_nibble = 4'h0;
    sel_dp     = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_nibble = disp_val_q[4*k +: 4];
        sel_dp     = disp_dp_q[k];
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (sel_nibble),
    .seg    (dec_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic upper_nz;

  // Blank a digit when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    upper_nz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((IDX_W'(k) >= idx_q) && (disp_val_q[4*k +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end
    seg_body = ((idx_q != '0) && !upper_nz) ? SEG_BLANK : dec_seg;
  end
`else
  assign seg_body = dec_seg;
`endif

  // Next-state: prescaler, digit index, load handshake and registered outputs
  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    wrap         = tick && (idx_q == IDX_LAST);
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    // A pending frame is swapped in only at the wrap; Ready is low while
    // pending, so a load and a transfer can never collide in one cycle.
    if (wrap && pend_flag_q) begin
      disp_val_d  = pend_val_q;
      disp_dp_d   = pend_dp_q;
      pend_flag_d = 1'b0;
    end else if (Load && !pend_flag_q) begin
      pend_val_d  = Value;
      pend_dp_d   = DP;
      pend_flag_d = 1'b1;
    end
    seg_d          = 8'h00;
    seg_d[SEG_DP]  = sel_dp;
    seg_d[SEG_G:SEG_A] = seg_body;
    sel_d          = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_d[k] = 1'b1;
      end
    end
    frame_done_d = wrap;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      seg_q        <= 8'h00;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Ready      = ~pend_flag_q;
  assign Segment    = seg_q;
  assign Digit_Sel  = sel_q;
  assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_segment_scanner.sv
// tb/tb_segment_scanner.sv - randomized self-checking bench for segment_scanner against a frame-position model
module tb_segment_scanner;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int FRAME = ND * SD;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [15:0] Value;
  logic [3:0]  DP;
  logic        Load;
  logic        Ready;
  logic [7:0]  Segment;
  logic [3:0]  Digit_Sel;
  logic        Frame_Done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: edges since reset, shown and pending frames
  int          m_edges;
  logic [15:0] m_disp_val, m_pend_val;
  logic [3:0]  m_disp_dp, m_pend_dp;
  bit          m_pend;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_fd;

  always #5 CLK = ~CLK;

  segment_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .Value      (Value),
    .DP         (DP),
    .Load       (Load),
    .Ready      (Ready),
    .Segment    (Segment),
    .Digit_Sel  (Digit_Sel),
    .Frame_Done (Frame_Done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, m_edges);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int d);
    logic [3:0]  nib;
    logic [15:0] above;
    logic [6:0]  body;
    nib   = 4'((m_disp_val >> (4 * d)) & 16'hF);
    above = m_disp_val >> (4 * d);
    body  = glyph(nib);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d > 0 && above == 16'h0) body = 7'h00;
`else
    if (above == 16'hDEAD) body = glyph(nib);
`endif
    return {m_disp_dp[d], body};
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare
  task automatic step();
    int  pos, d;
    bit  bnd;
    @(posedge CLK);
    if (!Reset_n) begin
      m_edges = 0; m_disp_val = '0; m_disp_dp = '0;
      m_pend_val = '0; m_pend_dp = '0; m_pend = 1'b0;
      exp_seg = 8'h00; exp_sel = 4'h0; exp_fd = 1'b0;
    end else begin
      pos     = m_edges % FRAME;
      d       = pos / SD;
      bnd     = (pos == FRAME - 1);
      exp_sel = 4'(1 << d);
      exp_seg = model_seg(d);
      exp_fd  = bnd;
      if (bnd && m_pend) begin
        m_disp_val = m_pend_val; m_disp_dp = m_pend_dp; m_pend = 1'b0;
      end else if (Load && !m_pend) begin
        m_pend_val = Value; m_pend_dp = DP; m_pend = 1'b1;
      end
      m_edges++;
    end
    #1;
    check_eq("segment", 32'(Segment), 32'(exp_seg));
    check_eq("digit_sel", 32'(Digit_Sel), 32'(exp_sel));
    check_eq("frame_done", 32'(Frame_Done), 32'(exp_fd));
    check_eq("ready", 32'(Ready), 32'(!m_pend));
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < FRAME && (m_edges % FRAME) != p; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    Value = v; DP = dp; Load = 1'b1;
    step();
    Load = 1'b0;
  endtask

  initial begin
    m_edges = 0; m_pend = 1'b0;
    m_disp_val = '0; m_disp_dp = '0; m_pend_val = '0; m_pend_dp = '0;
    Reset_n = 1'b0; Load = 1'b0; Value = '0; DP = '0;
    step(); step();
    Reset_n = 1'b1;
    repeat (2 * FRAME + 8) step();

    run_to_pos(6);
    do_load(16'h12AF, 4'b0100);
    repeat (3) step();
    do_load(16'hFFFF, 4'hF);
    repeat (3 * FRAME) step();

    run_to_pos(FRAME - 1);
    do_load(16'h3456, 4'b1001);
    repeat (2 * FRAME + 2) step();

    run_to_pos(3);
    do_load(16'h9876, 4'b0010);
    repeat (5) step();
    Reset_n = 1'b0; step();
    Reset_n = 1'b1;
    repeat (2 * FRAME) step();

`ifdef SEG_LEADING_ZERO_BLANK_EN
    run_to_pos(2);
    do_load(16'h0050, 4'b0000);
    repeat (2 * FRAME) step();
    do_load(16'h0000, 4'b0100);
    repeat (2 * FRAME + 2) step();
`endif

    for (int i = 0; i < 3000; i++) begin
      Reset_n = ($urandom_range(0, 399) != 0);
      Load    = ($urandom_range(0, 5) == 0);
      Value   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      DP      = 4'($urandom);
      step();
    end
    Reset_n = 1'b1; Load = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/segment_scanner.md
SEGMENT_SCANNER -- requirements
Module: segment_scanner

Interface
REQ-001 The parameter NUM_DIGITS SHALL default to 4 and set the number of multiplexed digits (legal 1..8).
REQ-002 The parameter SCAN_DIV SHALL default to 50000 and set the clocks each digit stays selected (legal >= 2).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 Reset_n  input  1  synchronous, active-low reset.
REQ-006 Value  input  4*NUM_DIGITS  hex nibbles to display; nibble k drives digit k, with digit 0 at bits [3:0].
REQ-007 DP  input  NUM_DIGITS  decimal-point enable per digit; captured together with Value.
REQ-008 Load  input  1  request to capture Value and DP.
REQ-009 Ready  output  1  high when a Load is accepted.
REQ-010 Segment  output  8  {dp,g,f,e,d,c,b,a}, active-high, registered.
REQ-011 Digit_Sel  output  NUM_DIGITS  one-hot digit enable, active-high, registered.
REQ-012 Frame_Done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 The prescaler SHALL count from 0 to SCAN_DIV-1 and wrap to 0; its terminal count is called tick.
REQ-014 On tick, the digit index SHALL advance 0,1,...,NUM_DIGITS-1 and wrap to 0; the wrap is the frame boundary.
REQ-015 The block SHALL hold three registers: a display register (shown), a pending register and a pending flag.
REQ-016 Load with Ready=1 SHALL copy Value and DP into the pending register, set the pending flag and drop Ready on the next cycle.
REQ-017 Load with Ready=0 SHALL be ignored, with no state change.
REQ-018 At the frame boundary with the pending flag set, the block SHALL copy the pending register into the display register, clear the flag and raise Ready on the next cycle.
REQ-019 Load accepted in the boundary cycle itself SHALL NOT transfer in that cycle; it transfers at the following boundary.
REQ-020 Digit_Sel and Segment SHALL be registered from the current index and the display register, one clock after each index change.
REQ-021 Segment[6:0] SHALL encode hex 0..F (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71).
REQ-022 Segment[7] SHALL equal the DP bit of the selected digit.
REQ-023 Frame_Done SHALL be asserted for exactly one cycle, in the cycle after the index wraps to 0.
REQ-024 With NUM_DIGITS=1 the index SHALL stay at 0, and every tick SHALL be a frame boundary.

Reset
REQ-025 Reset_n=0 at a clock edge SHALL clear the prescaler, index, display register, pending register and pending flag.
REQ-026 During reset, Segment SHALL be 8'h00, Digit_Sel 0, Frame_Done 0 and Ready 1.
REQ-027 A reset asserted mid-frame or with a load pending SHALL discard the pending data.
REQ-028 After reset release, digit 0 SHALL be selected from the first post-reset edge, showing 0 (8'h3F).

Configuration
REQ-029 With SEG_LEADING_ZERO_BLANK_EN defined, zero nibbles above the highest non-zero digit SHALL drive Segment[6:0]=0; digit 0 is never blanked, and DP still drives Segment[7].
REQ-030 Without SEG_LEADING_ZERO_BLANK_EN, every digit SHALL be decoded per REQ-021, and no blanking logic SHALL be present.

Structure
REQ-031 The segment encoding constants and the Segment bit-position constants SHALL live in the shared package seg_pkg.
REQ-032 The hex-to-segment decode SHALL be the combinational sub-module hex_to_seg, instanced once and fed by the selected nibble.
REQ-033 The prescaler, index, load handshake and blanking SHALL reside in segment_scanner.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-034 Reset release with no Load: Digit_Sel SHALL step 0001,0010,0100,1000 every 4 clocks with Segment=8'h3F, and Frame_Done SHALL pulse every 16 clocks.
REQ-035 Load Value=16'h12AF, DP=4'b0100 mid-frame: Ready SHALL drop and the display SHALL not change until the boundary. The next frame SHALL show 71,77,DB,06 on digits 0..3, and Ready SHALL rise.
REQ-036 A second Load while Ready=0 with Value=16'hFFFF: the block SHALL ignore it, and the frame after the transfer SHALL still show 12AF.
REQ-037 Load asserted in the boundary cycle: the display SHALL be unchanged for that frame and updated at the next boundary.
REQ-038 Reset_n pulsed low with a load pending: the pending data SHALL be lost, Ready SHALL be 1, and the display SHALL be all 3F.
REQ-039 With SEG_LEADING_ZERO_BLANK_EN, Value=16'h0050: digits 3 and 2 SHALL be 00, digit 1 SHALL be 6D, and digit 0 SHALL be 3F; Value=16'h0000 SHALL blank all digits except digit 0 (3F).
